uart_rx_word_assembler: RTL and testbench

UART receive front-end for the Posedge FTDI designs. It deserialises 8N1 bytes from the USB-UART line (UART_RX) and packs RX_SIZE/8 consecutive bytes into one RX_SIZE-bit word, little-endian. It presents each word on a valid/ready handshake to the downstream command/loopback/TX logic. It also reports framing errors, overruns and inter-byte timeouts.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_byte.sv | 136 +++++++++++++
 rtl/uart_rx_word_assembler.sv | 151 +++++++++++++++
 tb/tb_uart_rx_word_assembler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART receive path: receiver state
//            encoding, data-bit count and a ceil(log2) helper for sizing
//            counters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } uart_state_t;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_byte
// Purpose  : 8N1 byte receiver: two-flop input synchroniser, baud counter and
//            START/DATA/STOP/WAIT_HIGH state machine.
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            i_rx           - raw serial line, idle high
//            o_byte_data    - received byte (valid while o_byte_strobe is high)
//            o_byte_strobe  - high in the cycle the good stop bit is sampled
//            o_frame_err    - one-cycle pulse after a low stop bit
//            o_start        - high in the cycle a start edge is accepted
//            o_idle         - receiver is in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKDIV = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_byte_data,
   output logic       o_byte_strobe,
   output logic       o_frame_err,
   output logic       o_start,
   output logic       o_idle
);

   localparam int                c_CNT_W = clog2(CLKDIV);
   localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKDIV / 2);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKDIV - 1);
   localparam logic [2:0]         c_LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_prev;
   uart_state_t        r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_frame_err;

   logic               w_rxs;
   logic               w_fall;
   logic               w_bit_end;

   assign w_rxs     = r_sync2;
   assign w_fall    = r_prev & ~r_sync2;
   assign w_bit_end = (r_cnt == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_prev      <= 1'b1;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_sync1     <= i_rx;
         r_sync2     <= r_sync1;
         r_prev      <= r_sync2;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state <= START;
                  r_cnt   <= '0;
               end
            end
            START: begin
               if (r_cnt == c_HALF) begin
                  r_cnt <= '0;
                  // A line that is high again at mid start bit was a glitch.
                  if (!w_rxs) begin
                     r_state   <= DATA;
                     r_bit_idx <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rxs, r_shift[7:1]};
                  if (r_bit_idx == c_LAST_BIT) begin
                     r_state <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_rxs) begin
                     r_state <= IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= WAIT_HIGH;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               // Hold off until the line recovers so a break is not a start.
               if (w_rxs) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Strobe is combinational so the word register loads on the very edge
   // that samples the stop bit.
   assign o_byte_data   = r_shift;
   assign o_byte_strobe = (r_state == STOP) && w_bit_end && w_rxs;
   assign o_frame_err   = r_frame_err;
   assign o_start       = (r_state == IDLE) && w_fall;
   assign o_idle        = (r_state == IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_word_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_word_assembler
// Purpose  : Packs RX_SIZE/8 received UART bytes little-endian into a word and
//            offers it on a valid/ready handshake; flags framing errors,
//            overruns and inter-byte timeouts.
// Ports    : CLOCK     - system clock
//            RESET_N   - asynchronous active-low reset
//            UART_RX   - serial line, idle high
//            rx_data   - assembled word, first byte in [7:0]
//            rx_valid  - word available, held until accepted
//            rx_ready  - consumer accept
//            frame_err - one-cycle pulse on low stop bit
//            overrun   - one-cycle pulse when a completed word is dropped
//            timeout   - one-cycle pulse when a partial word is discarded
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_assembler
   import uart_pkg::*;
#(
   parameter int RX_SIZE      = 16,
   parameter int clkdiv_rx    = 100,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic               CLOCK,
   input  logic               RESET_N,
   input  logic               UART_RX,
   output logic [RX_SIZE-1:0] rx_data,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic               frame_err,
   output logic               overrun,
   output logic               timeout
);

   localparam int                  c_BYTES    = RX_SIZE / UART_DATA_BITS;
   localparam int                  c_IDX_W    = (c_BYTES > 1) ? clog2(c_BYTES) : 1;
   localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(c_BYTES - 1);

   logic [7:0]         w_byte_data;
   logic               w_byte_strobe;
   logic               w_frame_err;
   logic               w_start;
   logic               w_idle;
   logic               w_timeout_hit;
   logic               w_complete;
   logic               w_load_ok;
   logic [RX_SIZE-1:0] w_word;

   logic [RX_SIZE-1:0] r_shadow;
   logic [c_IDX_W-1:0] r_byte_idx;
   logic [RX_SIZE-1:0] r_rx_data;
   logic               r_rx_valid;
   logic               r_overrun;
   logic               r_timeout;

   uart_rx_byte #(
      .CLKDIV (clkdiv_rx)
   ) u_rx_byte (
      .clk           (CLOCK),
      .rst_n         (RESET_N),
      .i_rx          (UART_RX),
      .o_byte_data   (w_byte_data),
      .o_byte_strobe (w_byte_strobe),
      .o_frame_err   (w_frame_err),
      .o_start       (w_start),
      .o_idle        (w_idle)
   );

   // Partial word with the incoming byte dropped into its slot.
   always_comb begin
      w_word = r_shadow;
      w_word[{r_byte_idx, 3'b000} +: 8] = w_byte_data;
   end

   assign w_complete = w_byte_strobe && (r_byte_idx == c_LAST_IDX);
   assign w_load_ok  = !r_rx_valid || rx_ready;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_shadow   <= '0;
         r_byte_idx <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;

         if (w_frame_err) begin
            r_byte_idx <= '0;
         end else if (w_timeout_hit) begin
            r_byte_idx <= '0;
            r_timeout  <= 1'b1;
         end else if (w_byte_strobe) begin
            r_shadow   <= w_word;
            r_byte_idx <= w_complete ? '0 : r_byte_idx + 1'b1;
         end

         // A load in the handshake cycle keeps rx_valid high; an unaccepted
         // word is never overwritten.
         if (w_complete && w_load_ok) begin
            r_rx_data  <= w_word;
            r_rx_valid <= 1'b1;
         end else begin
            if (w_complete) begin
               r_overrun <= 1'b1;
            end
            if (r_rx_valid && rx_ready) begin
               r_rx_valid <= 1'b0;
            end
         end
      end
   end

   generate
      if (c_BYTES > 1) begin : g_timeout
         localparam int                 c_LIMIT = TIMEOUT_BITS * clkdiv_rx;
         localparam int                 c_TO_W  = clog2(c_LIMIT + 1);
         localparam logic [c_TO_W-1:0]  c_HIT   = c_TO_W'(c_LIMIT - 1);

         logic [c_TO_W-1:0] r_to_cnt;
         logic              w_run;

         assign w_run         = w_idle && (r_byte_idx != '0);
         assign w_timeout_hit = w_run && (r_to_cnt == c_HIT);

         always_ff @(posedge CLOCK or negedge RESET_N) begin
            if (!RESET_N) begin
               r_to_cnt <= '0;
            end else if (w_start || (r_byte_idx == '0)) begin
               r_to_cnt <= '0;
            end else if (w_run) begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end
      end else begin : g_no_timeout
         assign w_timeout_hit = 1'b0;
      end
   endgenerate

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = w_frame_err;
   assign overrun   = r_overrun;
   assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_word_assembler
// Purpose  : Self-checking bench for uart_rx_word_assembler (16-bit words,
//            100 clocks per bit).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_word_assembler;

   localparam int RX_SIZE      = 16;
   localparam int CLKDIV       = 100;
   localparam int TIMEOUT_BITS = 32;

   logic               CLOCK    = 1'b0;
   logic               RESET_N  = 1'b0;
   logic               UART_RX  = 1'b1;
   logic               rx_ready = 1'b0;
   logic [RX_SIZE-1:0] rx_data;
   logic               rx_valid;
   logic               frame_err;
   logic               overrun;
   logic               timeout;

   uart_rx_word_assembler #(
      .RX_SIZE      (RX_SIZE),
      .clkdiv_rx    (CLKDIV),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET_N   (RESET_N),
      .UART_RX   (UART_RX),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .timeout   (timeout)
   );

   always #5 CLOCK = ~CLOCK;

   int cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   // Observation of DUT outputs, sampled on the falling edge.
   logic [15:0] acc_q[$];
   int fe_cycles = 0, ov_cycles = 0, to_cycles = 0;
   int rise_cyc = 0, cur_len = 0, last_len = 0;
   logic prev_valid = 1'b0;

   always @(negedge CLOCK) begin
      if (rx_valid === 1'b1 && rx_ready === 1'b1) acc_q.push_back(rx_data);
      if (frame_err === 1'b1) fe_cycles = fe_cycles + 1;
      if (overrun === 1'b1)   ov_cycles = ov_cycles + 1;
      if (timeout === 1'b1)   to_cycles = to_cycles + 1;
      if (rx_valid === 1'b1) begin
         if (!prev_valid) begin
            rise_cyc = cyc;
            cur_len  = 1;
         end else begin
            cur_len = cur_len + 1;
         end
      end else if (prev_valid) begin
         last_len = cur_len;
      end
      prev_valid = (rx_valid === 1'b1);
   end

   int n_tests = 0;
   int n_fail  = 0;
   int start_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests = n_tests + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLOCK);
      #1;
   endtask

   // Serial frame: start, 8 data bits LSB first, stop bit of the given level.
   task automatic send_byte(input logic [7:0] b, input logic stop_level);
      UART_RX   = 1'b0;
      start_cyc = cyc;
      tick(CLKDIV);
      for (int i = 0; i < 8; i++) begin
         UART_RX = b[i];
         tick(CLKDIV);
      end
      UART_RX = stop_level;
      tick(CLKDIV);
      UART_RX = 1'b1;
   endtask

   // Reference: little-endian packing of two bytes.
   function automatic logic [15:0] word_of(input logic [7:0] b0, input logic [7:0] b1);
      return 16'(int'(b0) + 256 * int'(b1));
   endfunction

   task automatic check_word(input string tag, input logic [15:0] exp);
      check({tag, "_count"}, acc_q.size(), 1);
      if (acc_q.size() > 0) check(tag, acc_q.pop_front(), exp);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  b0, b1;
      logic [15:0] exp_q[$];
      int fe_snap, ov_snap, to_snap;

      // Reset state
      tick(3);
      sample();
      check("rst_data", rx_data, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_flags", {frame_err, overrun, timeout}, 0);
      RESET_N = 1'b1;
      tick(5);

      // 1: basic word, latency and one-cycle valid with ready high
      rx_ready = 1'b1;
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      tick(CLKDIV);
      sample();
      check_word("t1_word", word_of(8'h34, 8'h12));
      check("t1_latency_window",
            ((rise_cyc - start_cyc) >= 945 && (rise_cyc - start_cyc) <= 965) ? 1 : 0, 1);
      check("t1_valid_len", last_len, 1);

      // 2: overrun while the first word is held
      rx_ready = 1'b0;
      send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      tick(CLKDIV);
      sample();
      check("t2_valid_held", rx_valid, 1);
      check("t2_data_held", rx_data, word_of(8'hEF, 8'hBE));
      check("t2_overrun_cnt", ov_cycles, 1);
      check("t2_no_accept", acc_q.size(), 0);
      tick(1);
      rx_ready = 1'b1;
      tick(1);
      sample();
      check("t2_valid_drop", rx_valid, 0);
      check_word("t2_word", word_of(8'hEF, 8'hBE));

      // 3: framing error discards the partial word
      send_byte(8'h11, 1'b1);
      send_byte(8'h55, 1'b0);
      tick(2 * CLKDIV);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      tick(CLKDIV);
      sample();
      check("t3_frame_cnt", fe_cycles, 1);
      check_word("t3_word", word_of(8'hAA, 8'hBB));

      // 4: short glitch is a false start
      fe_snap = fe_cycles; ov_snap = ov_cycles; to_snap = to_cycles;
      UART_RX = 1'b0;
      tick(30);
      UART_RX = 1'b1;
      tick(2 * CLKDIV);
      sample();
      check("t4_valid", rx_valid, 0);
      check("t4_flags", (fe_cycles - fe_snap) + (ov_cycles - ov_snap) + (to_cycles - to_snap), 0);
      check("t4_no_word", acc_q.size(), 0);
      send_byte(8'h5A, 1'b1);
      send_byte(8'hC3, 1'b1);
      tick(CLKDIV);
      sample();
      check_word("t4_word", word_of(8'h5A, 8'hC3));

      // 5: inter-byte timeout
      send_byte(8'h77, 1'b1);
      tick(33 * CLKDIV);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      tick(CLKDIV);
      sample();
      check("t5_timeout_cnt", to_cycles, 1);
      check_word("t5_word", word_of(8'h01, 8'h02));

      // 6: reset during bit 4 of a byte, with a word pending
      rx_ready = 1'b0;
      send_byte(8'h9A, 1'b1);
      send_byte(8'h7E, 1'b1);
      tick(CLKDIV);
      sample();
      check("t6_pending", rx_valid, 1);
      b0 = 8'hC5;
      UART_RX = 1'b0;
      tick(CLKDIV);
      for (int i = 0; i < 4; i++) begin
         UART_RX = b0[i];
         tick(CLKDIV);
      end
      UART_RX = b0[4];
      tick(CLKDIV / 2);
      RESET_N = 1'b0;
      UART_RX = 1'b1;
      #1;
      check("t6_rst_data", rx_data, 0);
      check("t6_rst_valid", rx_valid, 0);
      check("t6_rst_flags", {frame_err, overrun, timeout}, 0);
      tick(3);
      RESET_N  = 1'b1;
      rx_ready = 1'b1;
      tick(5);
      send_byte(8'h10, 1'b1);
      send_byte(8'h20, 1'b1);
      tick(CLKDIV);
      sample();
      check_word("t6_word", word_of(8'h10, 8'h20));

      // Randomised words with random inter-byte gaps
      for (int k = 0; k < 6; k++) begin
         b0 = 8'($urandom_range(0, 255));
         b1 = 8'($urandom_range(0, 255));
         exp_q.push_back(word_of(b0, b1));
         send_byte(b0, 1'b1);
         tick($urandom_range(1, 3 * CLKDIV));
         send_byte(b1, 1'b1);
         tick($urandom_range(1, 3 * CLKDIV));
      end
      tick(CLKDIV);
      sample();
      check("rnd_count", acc_q.size(), exp_q.size());
      while (acc_q.size() > 0 && exp_q.size() > 0) begin
         check("rnd_word", acc_q.pop_front(), exp_q.pop_front());
      end

      check("tot_frame_err", fe_cycles, 1);
      check("tot_overrun", ov_cycles, 1);
      check("tot_timeout", to_cycles, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
